// File: rtl/sram_pkg.sv
// Shared types and constants for the SRAM responder.
//   state_t     : responder phase (boot load, one-cycle core release, normal run)
//   DATA_W      : bus word width (the core's SRAM bus is 16 bits)
//   SRAM_ADDR_W : width of the core's word address
//   HIZ16       : released value for the bidirectional data bus
package sram_pkg;

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2
  } state_t;

  localparam int DATA_W      = 16;
  localparam int SRAM_ADDR_W = 19;

  localparam logic [15:0] HIZ16 = 16'hzzzz;

endpackage

// File: rtl/sram_array.sv
// Single-port synchronous RAM: one write port and one registered read port
// sharing a single address.
//   clk       : clock, all activity on the rising edge
//   we_i      : write mem[addr_i] <= wdata_i
//   re_i      : update the read register this edge
//   rd_zero_i : load zero into the read register instead of memory contents
//   addr_i    : word address
//   wdata_i   : write data
//   rdata_o   : registered read data (one cycle latency)
// Contents are not reset so a reloaded image can partially overlay an old one.
module sram_array #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic              re_i,
  input  logic              rd_zero_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= rd_zero_i ? '0 : mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sram_responder.sv
// Block-RAM responder for the core's external-SRAM bus, with a boot loader.
// After reset the core is held in reset while a program image is streamed into
// RAM; then the core is released and the RAM answers its SRAM bus cycles.
//   clk, rst        : clock; asynchronous active-low reset
//   sram_addr       : word address from the core
//   sram_dq         : bidirectional data bus
//   sram_we_n       : active-low write enable (write wins over output enable)
//   sram_oe_n       : active-low output enable
//   ld_valid/ld_data/ld_last/ld_ready : loader stream
//   core_rst_n      : active-low reset to the core (high only in RUN)
//   load_done       : image loaded, core running
//   ld_overflow     : image reached the end of RAM without ld_last (sticky)
//   ld_count        : words accepted by the loader, saturates at 2^ADDR_W
//   dbg_state       : current FSM state
// Loader handshake: a word transfers on a rising edge where ld_valid and
// ld_ready are both 1; ld_ready never depends on ld_valid, and a source must
// hold ld_data/ld_last stable while ld_valid=1 and ld_ready=0.
module sram_responder
  import sram_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [SRAM_ADDR_W-1:0] sram_addr,
  inout  wire  [DATA_W-1:0]      sram_dq,
  input  logic                   sram_we_n,
  input  logic                   sram_oe_n,
  input  logic                   ld_valid,
  input  logic [DATA_W-1:0]      ld_data,
  input  logic                   ld_last,
  output logic                   ld_ready,
  output logic                   core_rst_n,
  output logic                   load_done,
  output logic                   ld_overflow,
  output logic [ADDR_W:0]        ld_count,
  output state_t                 dbg_state
);

  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'((2**ADDR_W) - 1);

  state_t          state_q, state_d;
  logic [ADDR_W:0] count_q, count_d;
  logic            ovf_q, ovf_d;
  logic            armed_q;

  logic              ld_fire;
  logic              in_range;
  logic              ram_we;
  logic              ram_re;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic              dq_oe;

  // armed_q keeps ld_ready low while reset is held and for the first edge after.
  assign ld_ready = (state_q == LOAD) && armed_q;
  assign ld_fire  = ld_valid && ld_ready;
  assign in_range = ~|sram_addr[SRAM_ADDR_W-1:ADDR_W];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= LOAD;
      count_q <= '0;
      ovf_q   <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      armed_q <= 1'b1;
    end
  end

  // count_q reaches 2^ADDR_W only on the final slot, which always leaves LOAD,
  // so the counter saturates without an explicit guard.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    case (state_q)
      LOAD: begin
        if (ld_fire) begin
          count_d = count_q + 1'b1;
          if (ld_last) begin
            state_d = RELEASE;
          end else if (count_q == LAST_IDX) begin
            ovf_d   = 1'b1;
            state_d = RELEASE;
          end
        end
      end
      RELEASE: state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = LOAD;
    endcase
  end

  // RAM port mux: loader owns the write port in LOAD, the core bus in RUN.
  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = sram_addr[ADDR_W-1:0];
    ram_wdata = sram_dq;
    if (state_q == LOAD) begin
      ram_we    = ld_fire;
      ram_addr  = count_q[ADDR_W-1:0];
      ram_wdata = ld_data;
    end else if (state_q == RUN) begin
      ram_we = ~sram_we_n & in_range;
    end
  end

  assign ram_re = (state_q == RUN) && sram_we_n;

  sram_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clk       (clk),
    .we_i      (ram_we),
    .re_i      (ram_re),
    .rd_zero_i (~in_range),
    .addr_i    (ram_addr),
    .wdata_i   (ram_wdata),
    .rdata_o   (ram_rdata)
  );

  // Combinational enable so dq is released in the same cycle oe_n rises.
  assign dq_oe   = ~sram_oe_n & sram_we_n & (state_q == RUN);
  assign sram_dq = dq_oe ? ram_rdata : HIZ16;

  assign core_rst_n  = (state_q == RUN);
  assign load_done   = (state_q == RUN);
  assign ld_overflow = ovf_q;
  assign ld_count    = count_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_sram_responder.sv
module tb_sram_responder;
  import sram_pkg::*;

  // Undriven bus reads back as all ones through the pull-ups.
  localparam logic [15:0] ZREAD = 16'hFFFF;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- main instance (ADDR_W=10) ----------------
  logic [18:0] sram_addr;
  logic        sram_we_n;
  logic        sram_oe_n;
  logic        ld_valid;
  logic [15:0] ld_data;
  logic        ld_last;
  logic        ld_ready;
  logic        core_rst_n;
  logic        load_done;
  logic        ld_overflow;
  logic [10:0] ld_count;
  state_t      d_state;
  logic        tb_drv;
  logic [15:0] tb_dq;
  wire  [15:0] dq;

  assign dq = tb_drv ? tb_dq : 16'hzzzz;
  for (genvar gi = 0; gi < 16; gi++) begin : g_pu
    pullup (dq[gi]);
  end

  sram_responder #(.ADDR_W(10), .DATA_W(16)) u_dut (
    .clk         (clk),
    .rst         (rst),
    .sram_addr   (sram_addr),
    .sram_dq     (dq),
    .sram_we_n   (sram_we_n),
    .sram_oe_n   (sram_oe_n),
    .ld_valid    (ld_valid),
    .ld_data     (ld_data),
    .ld_last     (ld_last),
    .ld_ready    (ld_ready),
    .core_rst_n  (core_rst_n),
    .load_done   (load_done),
    .ld_overflow (ld_overflow),
    .ld_count    (ld_count),
    .dbg_state   (d_state)
  );

  // ---------------- overflow instance (ADDR_W=4) ----------------
  logic [18:0] o_addr;
  logic        o_oe_n;
  logic        o_valid;
  logic [15:0] o_data;
  logic        o_ready;
  logic        o_crn;
  logic        o_done;
  logic        o_ovf;
  logic [4:0]  o_count;
  state_t      o_state;
  wire  [15:0] dq2;

  for (genvar gi = 0; gi < 16; gi++) begin : g_pu2
    pullup (dq2[gi]);
  end

  sram_responder #(.ADDR_W(4), .DATA_W(16)) u_ovf (
    .clk         (clk),
    .rst         (rst),
    .sram_addr   (o_addr),
    .sram_dq     (dq2),
    .sram_we_n   (1'b1),
    .sram_oe_n   (o_oe_n),
    .ld_valid    (o_valid),
    .ld_data     (o_data),
    .ld_last     (1'b0),
    .ld_ready    (o_ready),
    .core_rst_n  (o_crn),
    .load_done   (o_done),
    .ld_overflow (o_ovf),
    .ld_count    (o_count),
    .dbg_state   (o_state)
  );

  // ---------------- scoreboard ----------------
  int vectors     = 0;
  int miscompares = 0;
  logic [15:0] img [8];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Every task returns at a falling edge; inputs change and outputs are sampled there.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Streams img[0..n-1]; returns at the falling edge after the last transfer.
  task automatic load_words(input int n, input bit rnd);
    int idx = 0;
    int cyc = 0;
    while (idx < n && cyc < 200) begin
      ld_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      ld_data  = ld_valid ? img[idx] : 16'hDEAD;
      ld_last  = (idx == n - 1);
      #1;
      if (ld_valid && ld_ready) idx++;
      tick();
      cyc++;
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    ld_data  = 16'hDEAD;
    chk("load_words_accepted", idx, n);
  endtask

  task automatic bus_write(input logic [18:0] a, input logic [15:0] d);
    sram_addr = a;
    sram_we_n = 1'b0;
    sram_oe_n = 1'b1;
    tb_dq     = d;
    tb_drv    = 1'b1;
    tick();
    sram_we_n = 1'b1;
    tb_drv    = 1'b0;
  endtask

  task automatic bus_read(input logic [18:0] a, input logic [15:0] exp, input string tag);
    sram_addr = a;
    sram_we_n = 1'b1;
    sram_oe_n = 1'b0;
    tb_drv    = 1'b0;
    tick();
    chk(tag, dq, exp);
  endtask

  task automatic ovf_read(input logic [18:0] a, input logic [15:0] exp, input string tag);
    o_addr = a;
    o_oe_n = 1'b0;
    tick();
    chk(tag, dq2, exp);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int  sent;
    bit  seen15;

    rst       = 1'b1;
    sram_addr = '0;
    sram_we_n = 1'b1;
    sram_oe_n = 1'b0;   // oe asserted during LOAD: dq must stay released anyway
    ld_valid  = 1'b0;
    ld_data   = 16'hDEAD;
    ld_last   = 1'b0;
    tb_drv    = 1'b0;
    tb_dq     = '0;
    o_addr    = '0;
    o_oe_n    = 1'b1;
    o_valid   = 1'b0;
    o_data    = '0;

    // Reset state
    #2 rst = 1'b0;
    #2;
    chk("rst_core_rst_n", core_rst_n, 1'b0);
    chk("rst_load_done", load_done, 1'b0);
    chk("rst_ld_overflow", ld_overflow, 1'b0);
    chk("rst_ld_count", ld_count, 11'd0);
    chk("rst_state", d_state, LOAD);
    chk("rst_dq_hiz", dq, ZREAD);
    @(negedge clk);
    @(negedge clk);
    chk("rst_ld_ready_held", ld_ready, 1'b0);
    rst = 1'b1;
    #1;
    chk("ld_ready_before_first_edge", ld_ready, 1'b0);
    tick();
    chk("ld_ready_after_release", ld_ready, 1'b1);

    // Load 4 words with random valid gaps
    img[0] = 16'h1111; img[1] = 16'h2222; img[2] = 16'h3333; img[3] = 16'h4444;
    load_words(4, 1'b1);
    // Cycle after the last transfer is RELEASE; the core comes out of reset
    // on the following edge.
    chk("release_state", d_state, RELEASE);
    chk("release_core_rst_n", core_rst_n, 1'b0);
    chk("release_ld_ready", ld_ready, 1'b0);
    chk("load_ld_count", ld_count, 11'd4);
    chk("load_dq_hiz", dq, ZREAD);
    tick();
    chk("run_core_rst_n", core_rst_n, 1'b1);
    chk("run_load_done", load_done, 1'b1);
    chk("run_state", d_state, RUN);
    chk("run_ld_ready", ld_ready, 1'b0);

    // Read back the image
    bus_read(19'd0, 16'h1111, "read_a0");
    bus_read(19'd1, 16'h2222, "read_a1");
    bus_read(19'd2, 16'h3333, "read_a2");
    bus_read(19'd3, 16'h4444, "read_a3");

    // Write then read the next cycle; dq released as soon as oe_n rises
    bus_write(19'd7, 16'hBEEF);
    bus_read(19'd7, 16'hBEEF, "wr_rd_a7");
    sram_oe_n = 1'b1;
    #1;
    chk("oe_n_high_hiz", dq, ZREAD);

    // we_n and oe_n both low: write wins, responder does not drive
    sram_addr = 19'd8;
    sram_we_n = 1'b0;
    sram_oe_n = 1'b0;
    tb_dq     = 16'h5A5A;
    tb_drv    = 1'b1;
    #1;
    chk("we_oe_no_contention", dq, 16'h5A5A);
    tick();
    sram_we_n = 1'b1;
    tb_drv    = 1'b0;
    bus_read(19'd8, 16'h5A5A, "we_oe_write_landed");

    // Out of range: dropped write, zero read, no alias onto address 0
    bus_write(19'h00400, 16'h1234);
    bus_read(19'h00400, 16'h0000, "oor_read_zero");
    bus_read(19'd0, 16'h1111, "oor_no_alias_a0");

    // Mid-run reset
    rst = 1'b0;
    #1;
    chk("midrst_core_rst_n", core_rst_n, 1'b0);
    chk("midrst_state", d_state, LOAD);
    chk("midrst_ld_count", ld_count, 11'd0);
    chk("midrst_load_done", load_done, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    // Bus write attempts to address 2 during reload must be ignored
    sram_addr = 19'd2;
    sram_we_n = 1'b0;
    sram_oe_n = 1'b1;
    tb_dq     = 16'hEEEE;
    tb_drv    = 1'b1;
    tick();
    img[0] = 16'hAAAA; img[1] = 16'hBBBB;
    load_words(2, 1'b0);
    sram_we_n = 1'b1;
    tb_drv    = 1'b0;
    chk("reload_ld_count", ld_count, 11'd2);
    tick();
    chk("reload_run_state", d_state, RUN);
    bus_read(19'd0, 16'hAAAA, "reload_a0");
    bus_read(19'd1, 16'hBBBB, "reload_a1");
    bus_read(19'd2, 16'h3333, "reload_a2_kept");
    bus_read(19'd7, 16'hBEEF, "reload_a7_kept");
    sram_oe_n = 1'b1;

    // Overflow on the 16-word instance: 17 words offered, no ld_last
    sent   = 0;
    seen15 = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (sent == 15 && !seen15) begin
        chk("ovf_not_early", o_ovf, 1'b0);
        seen15 = 1'b1;
      end
      o_valid = (sent < 17);
      o_data  = 16'h0100 + 16'(sent);
      #1;
      if (o_valid && o_ready) sent++;
      tick();
    end
    o_valid = 1'b0;
    chk("ovf_accepted", sent, 16);
    chk("ovf_ld_count", o_count, 5'd16);
    chk("ovf_flag", o_ovf, 1'b1);
    chk("ovf_ld_ready", o_ready, 1'b0);
    chk("ovf_state", o_state, RUN);
    chk("ovf_core_rst_n", o_crn, 1'b1);
    chk("ovf_load_done", o_done, 1'b1);
    ovf_read(19'd0, 16'h0100, "ovf_a0_no_wrap");
    ovf_read(19'd15, 16'h010F, "ovf_a15");
    ovf_read(19'd16, 16'h0000, "ovf_oor_read");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
